uart_rx: RTL

8N1 UART receiver, the receive-side counterpart of the existing 9600-baud transmitter on the 100 MHz system clock. It uses 16x oversampling, a 2-flop input synchronizer, 3-sample majority voting, false-start rejection and framing-error detection. Each received byte is held in a one-deep holding register with a rdy/ack handshake and overrun reporting.

---
 rtl/uart_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, 16x oversampling with 3-sample majority
//                vote, false-start rejection, framing-error detection and a
//                one-deep rdy/ack holding register with overrun reporting.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int OS_DIV  = 651,
    parameter int OS_RATE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rdy,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [11:0] c_DIV_LAST  = 12'(OS_DIV - 1);
    localparam logic [3:0]  c_S_FIRST   = 4'(OS_RATE / 2 - 1);
    localparam logic [3:0]  c_S_SECOND  = 4'(OS_RATE / 2);
    localparam logic [3:0]  c_S_VOTE    = 4'(OS_RATE / 2 + 1);
    localparam logic [3:0]  c_S_LAST    = 4'(OS_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sync1;
    logic        r_sync2;
    logic [11:0] r_div_cnt;
    logic [3:0]  r_s_cnt;
    logic [2:0]  r_bit_cnt;
    logic        r_smp_a;
    logic        r_smp_b;
    logic [7:0]  r_shift;
    logic [7:0]  r_dout;
    logic        r_rdy;
    logic        r_frame_err;
    logic        r_overrun;

    logic        w_rx_s;
    logic        w_tick;
    logic        w_vote_pt;
    logic        w_wrap;
    logic        w_vote;
    logic        w_state_chg;
    logic        w_shift_en;
    logic        w_deliver;
    logic        w_ferr;

    assign w_rx_s      = r_sync2;
    assign w_tick      = (r_state != ST_IDLE) && (r_div_cnt == c_DIV_LAST);
    assign w_vote_pt   = w_tick && (r_s_cnt == c_S_VOTE);
    assign w_wrap      = w_tick && (r_s_cnt == c_S_LAST);
    // third sample is the live line value on the vote tick itself
    assign w_vote      = (r_smp_a & r_smp_b) | (r_smp_a & w_rx_s) | (r_smp_b & w_rx_s);
    assign w_state_chg = (w_state_nxt != r_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= ST_IDLE;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_vote_pt && w_vote) w_state_nxt = ST_IDLE;
                else if (w_wrap)         w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_vote_pt) w_shift_en = 1'b1;
                if (w_wrap && (r_bit_cnt == 3'd7)) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // decide at mid-stop so a following start edge is never missed
                if (w_vote_pt) begin
                    w_state_nxt = ST_IDLE;
                    w_deliver   = w_vote;
                    w_ferr      = ~w_vote;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= 12'd0;
            r_s_cnt   <= 4'd0;
            r_bit_cnt <= 3'd0;
            r_smp_a   <= 1'b0;
            r_smp_b   <= 1'b0;
            r_shift   <= 8'h00;
        end else begin
            if ((r_state == ST_IDLE) || w_tick) r_div_cnt <= 12'd0;
            else                                r_div_cnt <= r_div_cnt + 12'd1;

            if (w_state_chg) r_s_cnt <= 4'd0;
            else if (w_tick) r_s_cnt <= r_s_cnt + 4'd1;

            if (r_state != ST_DATA) r_bit_cnt <= 3'd0;
            else if (w_wrap)        r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_tick && (r_s_cnt == c_S_FIRST))  r_smp_a <= w_rx_s;
            if (w_tick && (r_s_cnt == c_S_SECOND)) r_smp_b <= w_rx_s;

            if (w_shift_en) r_shift <= {w_vote, r_shift[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout      <= 8'h00;
            r_rdy       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                r_dout    <= r_shift;
                r_rdy     <= 1'b1;
                r_overrun <= r_rdy & ~ack;
            end else if (r_rdy && ack) begin
                r_rdy <= 1'b0;
            end
        end
    end

    assign dout      = r_dout;
    assign rdy       = r_rdy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
